mano_seq_control: RTL

- Sequencing core of the basic computer: sequence counter (SC), timing decoder, D/I instruction latch, start/stop flip-flop (S), and interrupt flip-flops (IEN, R).
- Drives the T, D, I and R signals consumed by the memory, register and ALU control decoders.
- Takes back only clear-SC, halt and interrupt-enable pulses from those decoders.

---
 rtl/mano_seq_control_if.sv | 28 ++
 rtl/mano_seq_control.sv | 68 ++++++
 2 files changed

// File: rtl/mano_seq_control_if.sv
// mano_seq_control_if: control bus between the sequencer and the memory/register/ALU decoders.
// Decoders drive the pulses and IR fields; the sequencer drives timing and latched decode.
interface mano_seq_control_if #(parameter int NUM_T = 8);
    logic             start;
    logic             halt;
    logic             clr_sc;
    logic [2:0]       ir_op;
    logic             ir_i;
    logic             ion;
    logic             iof;
    logic             fgi;
    logic             fgo;
    logic [NUM_T-1:0] t;
    logic [7:0]       d;
    logic             i;
    logic             r;
    logic             ien;
    logic             running;
    logic             seq_err;
    modport master (
        output start, halt, clr_sc, ir_op, ir_i, ion, iof, fgi, fgo,
        input  t, d, i, r, ien, running, seq_err
    );
    modport slave (
        input  start, halt, clr_sc, ir_op, ir_i, ion, iof, fgi, fgo,
        output t, d, i, r, ien, running, seq_err
    );
endinterface

// File: rtl/mano_seq_control.sv
// mano_seq_control: sequence counter, timing decode, D/I latch, S flip-flop and IEN/R interrupt logic.
module mano_seq_control #(
    parameter int NUM_T = 8
) (
    input logic               clk,
    input logic               rst_n,
    mano_seq_control_if.slave bus
);
    localparam int SCW = $clog2(NUM_T);
    logic [SCW-1:0]   r_sc;
    logic             r_run;
    logic [7:0]       r_d;
    logic             r_i;
    logic             r_r;
    logic             r_ien;
    logic             r_err;
    logic [NUM_T-1:0] w_t;
    logic             w_adv;
    logic             w_rt2;
    logic             w_set;
    // w_adv: a normal sequencing edge, not overridden by a start/halt pulse
    always_comb begin
        w_t   = r_run ? NUM_T'(1) << r_sc : '0;
        w_adv = r_run & ~bus.halt & ~bus.start;
        w_rt2 = w_adv & r_r & w_t[2];
        w_set = w_adv & ~|w_t[2:0] & r_ien & (bus.fgi | bus.fgo);
    end
    assign bus.t       = w_t;
    assign bus.d       = r_d;
    assign bus.i       = r_i;
    assign bus.r       = r_r;
    assign bus.ien     = r_ien;
    assign bus.running = r_run;
    assign bus.seq_err = r_err;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sc  <= '0;
            r_run <= 1'b0;
            r_d   <= '0;
            r_i   <= 1'b0;
            r_r   <= 1'b0;
            r_ien <= 1'b0;
            r_err <= 1'b0;
        end else begin
            if (bus.halt) begin
                r_run <= 1'b0;
                r_sc  <= '0;
            end else if (bus.start) begin
                r_run <= 1'b1;
                r_sc  <= '0;
            end else if (r_run) begin
                if (bus.clr_sc | w_rt2) r_sc <= '0;
                else if (r_sc == SCW'(NUM_T - 1)) begin
                    r_sc  <= '0;
                    r_err <= 1'b1;
                end else r_sc <= r_sc + SCW'(1);
            end
            if (w_adv & ~r_r & w_t[2]) begin
                r_d <= 8'(1) << bus.ir_op;
                r_i <= bus.ir_i;
            end
            if (w_rt2) r_r <= 1'b0;
            else if (w_set) r_r <= 1'b1;
            if (w_rt2 | bus.iof) r_ien <= 1'b0;
            else if (bus.ion) r_ien <= 1'b1;
        end
    end
endmodule
